hack_mem_arbiter: RTL

//  Shares the single-port Hack data RAM between the CPU data port and the video

---
 rtl/hack_mem_pkg.sv | 22 ++
 rtl/hack_addr_decode.sv | 19 +
 rtl/hack_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared constants and enumerations for the Hack data-RAM arbiter.
package hack_mem_pkg;

    // RAM word address of screen offset 0 and of the keyboard register.
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;

    // Data-phase state of the arbiter: which access, if any, owns this cycle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_DATA = 2'd1,
        VID_DATA = 2'd2
    } state_e;

    // CPU address region: real RAM, the keyboard register, or unmapped space.
    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_KBD  = 2'd1,
        RGN_NONE = 2'd2
    } region_e;

endpackage

// File: rtl/hack_addr_decode.sv
// Combinational decode of a 15-bit CPU word address into its region.
module hack_addr_decode
    import hack_mem_pkg::*;
(
    input  logic [14:0] addr_i,
    output region_e     region_o
);

    // Below the keyboard is RAM, the keyboard is one word, everything above reads as 0.
    always_comb begin
        region_o = RGN_NONE;
        if (addr_i < KBD_ADDR) begin
            region_o = RGN_RAM;
        end else if (addr_i == KBD_ADDR) begin
            region_o = RGN_KBD;
        end
    end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port Hack data RAM between the CPU data port and the video
// scanout reader, and maps the keyboard register at 0x6000.
//
// Handshakes: both requesters hold a level request with stable address/data
// until served. Video is served in the cycle vid_ack pulses (issue cycle) and
// its data arrives with vid_rvalid one cycle later. The CPU is served at the
// edge ending its issue cycle; cpu_ce pulses in the following data-phase cycle,
// and a cpu_req still high during that cycle is the old, already-served access.
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [14:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ce,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [15:0] vid_rdata,
    input  logic [15:0] kbd_data,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [1:0]  dbg_state
);

    localparam int                WAIT_W   = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    state_e             state_q, state_d;
    region_e            region_q, region_d;
    region_e            cpu_region;
    logic [WAIT_W-1:0]  cpu_wait_q, cpu_wait_d;
    logic [14:0]        ram_addr_q, ram_addr_d;
    logic [15:0]        ram_wdata_q, ram_wdata_d;
    logic               ram_we_q, ram_we_d;

    logic               cpu_elig;
    logic               cpu_grant;
    logic               vid_grant;

    hack_addr_decode u_decode (
        .addr_i   (cpu_addr),
        .region_o (cpu_region)
    );

    // Video wins by default; the CPU wins once it has lost CPU_MAX_WAIT times.
    assign cpu_elig  = cpu_req && (state_q != CPU_DATA);
    assign cpu_grant = cpu_elig && (!vid_req || (cpu_wait_q == WAIT_MAX));
    assign vid_grant = vid_req && !cpu_grant;

    // Ack is the issue-cycle pulse; it must stay low while reset is held.
    assign vid_ack   = vid_grant && !reset;

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign dbg_state = state_q;

    // Next-state: issue the winning access into the RAM registers for its data phase.
    always_comb begin
        state_d     = IDLE;
        region_d    = region_q;
        cpu_wait_d  = cpu_wait_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (cpu_grant) begin
            state_d     = CPU_DATA;
            region_d    = cpu_region;
            cpu_wait_d  = '0;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            // Writes to the keyboard or unmapped space never reach the RAM.
            ram_we_d    = cpu_we && (cpu_region == RGN_RAM);
        end else if (vid_grant) begin
            state_d    = VID_DATA;
            ram_addr_d = SCREEN_BASE + {2'b00, vid_addr};
        end
        if (!cpu_grant && cpu_elig && (cpu_wait_q != WAIT_MAX)) begin
            cpu_wait_d = cpu_wait_q + 1'b1;
        end
    end

    // State and RAM-side registers; reset drops any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            region_q    <= RGN_NONE;
            cpu_wait_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cpu_wait_q  <= cpu_wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
        end
    end

    // Data-phase outputs: completion pulses and the read-data mux.
    always_comb begin
        cpu_ce     = 1'b0;
        cpu_rdata  = '0;
        vid_rvalid = 1'b0;
        vid_rdata  = '0;
        case (state_q)
            CPU_DATA: begin
                cpu_ce = 1'b1;
                case (region_q)
                    RGN_RAM: cpu_rdata = ram_rdata;
                    RGN_KBD: cpu_rdata = kbd_data;
                    default: cpu_rdata = '0;
                endcase
            end
            VID_DATA: begin
                vid_rvalid = 1'b1;
                vid_rdata  = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule
